// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;
  localparam int QDEPTH_DEF  = 2;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake: {pc, instr} head with valid/ready.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();
  logic               OutValid;
  logic               OutReady;
  logic [INSTR_W-1:0] OutInstr;
  logic [ADDR_W-1:0]  OutPC;

  modport master (output OutValid, OutInstr, OutPC, input OutReady);
  modport slave  (input OutValid, OutInstr, OutPC, output OutReady);
endinterface

// File: rtl/fetch_queue.sv
// Registered {pc, instr} FIFO with push/pop/flush; head reads zero when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int QDEPTH  = QDEPTH_DEF
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         push_pc,
  input  logic [INSTR_W-1:0]        push_instr,
  output logic [$clog2(QDEPTH):0]   count,
  output logic [ADDR_W-1:0]         head_pc,
  output logic [INSTR_W-1:0]        head_instr
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [QDEPTH-1:0][ADDR_W-1:0]  pc_mem;
  logic [QDEPTH-1:0][INSTR_W-1:0] instr_mem;
  logic [PTR_W-1:0]               rd_ptr, wr_ptr;
  logic                           do_pop;

  assign do_pop = pop && (count != '0);

  // Pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  assign head_pc    = (count != '0) ? pc_mem[rd_ptr]    : '0;
  assign head_instr = (count != '0) ? instr_mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_controller.sv
// Fetch PC owner, RUN/STALL/HALTED sequencer and branch redirect.
// Optional perf counters (FetchCount/StallCount) under `FETCH_PERF_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                QDEPTH   = QDEPTH_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  fetch_if.master            dq,
  output logic [ADDR_W-1:0]  RomAddr,
  input  logic [INSTR_W-1:0] RomData,
  input  logic               BranchValid,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic               Halt,
  input  logic               Resume,
  output logic               Halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        FetchCount,
  output logic [31:0]        StallCount
`endif
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, pc_nxt;
  logic [CNT_W-1:0]  count;
  logic              pop, push, space;

  assign pop   = dq.OutValid && dq.OutReady;
  assign space = (count < CNT_W'(QDEPTH)) || pop;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
    end
  end

  always_comb begin
    push      = 1'b0;
    pc_nxt    = fetch_pc;
    state_nxt = state;
    if (BranchValid) begin
      // Redirect wins over push/stall; halt bookkeeping still applies.
      pc_nxt = BranchTarget;
      if (state == HALTED) state_nxt = (Resume && !Halt) ? RUN : HALTED;
      else                 state_nxt = Halt ? HALTED : RUN;
    end else begin
      unique case (state)
        RUN, STALL: begin
          if (Halt) begin
            state_nxt = HALTED;
          end else if (space) begin
            push      = 1'b1;
            pc_nxt    = fetch_pc + 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = STALL;
          end
        end
        HALTED:  if (Resume && !Halt) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH)) u_queue (
    .Clock      (Clock),
    .Reset      (Reset),
    .push       (push),
    .pop        (pop),
    .flush      (BranchValid),
    .push_pc    (fetch_pc),
    .push_instr (RomData),
    .count      (count),
    .head_pc    (dq.OutPC),
    .head_instr (dq.OutInstr)
  );

  assign dq.OutValid = (count != '0);
  assign RomAddr     = fetch_pc;
  assign Halted      = (state == HALTED);

`ifdef FETCH_PERF_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (push)           FetchCount <= sat_inc(FetchCount);
      if (state == STALL) StallCount <= sat_inc(StallCount);
    end
  end
`endif
endmodule
